e203_exu_mt_regfile: RTL and testbench
======================================

E203_EXU_MT_REGFILE -- requirements
Module: e203_exu_mt_regfile

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning the register data width.
REQ-002 SHALL have parameter RFIDX_W, default 5, meaning the register index width; NREG = 2^RFIDX_W registers per thread.
REQ-003 SHALL have parameter THREADS, default 2, meaning the number of hardware thread contexts.
REQ-004 SHALL have parameter TID_W, default 1, meaning the thread-id width; requires 2^TID_W >= THREADS.
REQ-005 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have read port A: read_src1_tid in TID_W, read_src1_idx in RFIDX_W, read_src1_dat out XLEN.
REQ-008 SHALL have read port B: read_src2_tid in TID_W, read_src2_idx in RFIDX_W, read_src2_dat out XLEN.
REQ-009 SHALL have write port 0: wbck0_wen in 1, wbck0_tid in TID_W, wbck0_idx in RFIDX_W, wbck0_dat in XLEN.
REQ-010 SHALL have write port 1: wbck1_wen in 1, wbck1_tid in TID_W, wbck1_idx in RFIDX_W, wbck1_dat in XLEN.
REQ-011 SHALL have the context-clear interface: clr_req in 1, clr_tid in TID_W, clr_busy out 1, clr_done out 1.
REQ-012 SHALL have x1_r, output, THREADS*XLEN, holding the x1 of thread t in bits [t*XLEN +: XLEN].

Function
REQ-013 SHALL store THREADS x NREG registers of XLEN bits; register x0 of every thread reads as zero and ignores writes.
REQ-014 SHALL write wbckN_dat to [wbckN_tid][wbckN_idx] at the rising edge when wbckN_wen=1, idx!=0, and the write is not dropped per REQ-019.
REQ-015 SHALL let port 1 win when both ports target the same tid and idx in one cycle; port 0 data is discarded.
REQ-016 SHALL make reads combinational: dat = the stored value at [tid][idx].
REQ-017 SHALL bypass write to read: a read whose tid/idx matches an accepted write in the same cycle returns that write's data (port 1 over port 0); idx 0 always returns 0.
REQ-018 SHALL implement a clear FSM with states IDLE and CLEAR; in IDLE, clr_req=1 latches clr_tid, sets counter=1, and enters CLEAR on the next edge.
REQ-019 SHALL, in CLEAR, write zero to [latched tid][counter] each cycle and increment the counter; port writes to the latched tid are dropped (not stored, not bypassed); writes to other tids proceed normally.
REQ-020 SHALL, in CLEAR with counter = NREG-1, perform the last zero write and return to IDLE on that edge; clr_busy=1 exactly during CLEAR (NREG-1 cycles).
REQ-021 SHALL pulse clr_done for exactly one cycle, in the first IDLE cycle after CLEAR.
REQ-022 SHALL ignore clr_req while in CLEAR (no queueing); clr_req in the same cycle as clr_done is accepted.
REQ-023 SHALL not bypass clear zero-writes to reads; a read of the cleared tid returns the stored (pre-clear or zeroed) value.
REQ-024 SHALL ignore clr_tid >= THREADS, and ignore writes or reads with tid >= THREADS; such reads return 0.

Reset
REQ-025 SHALL, with rst=1 at a rising edge, zero all registers, set the FSM to IDLE and the counter to 0, and drive clr_busy=0, clr_done=0, x1_r=0.
REQ-026 SHALL abort an in-progress clear on reset; no clr_done pulse follows.

Verification
REQ-027 SHALL pass write/read: wbck0 writes t0 x5=0xDEADBEEF -> next cycle read_src1(t0,5)=0xDEADBEEF, read_src2(t1,5)=0.
REQ-028 SHALL pass collision/bypass: in one cycle wbck0 writes t1 x7=0x11 and wbck1 writes t1 x7=0x22, with read_src1(t1,7) -> read shows 0x22 the same cycle and stores 0x22.
REQ-029 SHALL pass x0: wbck1 writes t0 x0=0xFFFFFFFF -> read_src1(t0,0)=0 and read_src2(t0,0)=0.
REQ-030 SHALL pass clear: fill t1 x1..x31 with nonzero values, then clr_req(t1) -> clr_busy high 31 cycles, clr_done for 1 cycle, all t1 regs 0, t0 regs unchanged, x1_r[t1 slice]=0.
REQ-031 SHALL pass clear/write interaction: during a t0 clear, wbck0 writes t0 x3=5 and wbck1 writes t1 x3=9 -> t0 x3=0 after clear, t1 x3=9, and the t0 read shows no bypass.
REQ-032 SHALL pass reset mid-clear: assert rst at counter=10 -> next cycle clr_busy=0, clr_done=0, and all registers 0.

Source files
------------

// File: rtl/e203_exu_mt_regfile.sv
// Multi-thread integer register file: 2 read / 2 write ports per cycle, with a
// background FSM that zeroes one thread's context while other threads keep running.

module e203_exu_mt_regfile_ctx #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int NREG    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          w0_en,
  input  logic [RFIDX_W-1:0]            w0_idx,
  input  logic [XLEN-1:0]               w0_dat,
  input  logic                          w1_en,
  input  logic [RFIDX_W-1:0]            w1_idx,
  input  logic [XLEN-1:0]               w1_dat,
  input  logic                          clr_en,
  input  logic [RFIDX_W-1:0]            clr_idx,
  output logic [NREG-1:0][XLEN-1:0]     rf
);
  // x0 has no storage; it is tied to zero on the read side.
  logic [XLEN-1:0] mem [1:NREG-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 1; r < NREG; r++) mem[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (clr_en && clr_idx == RFIDX_W'(r))     mem[r] <= '0;
        else if (w1_en && w1_idx == RFIDX_W'(r))  mem[r] <= w1_dat;
        else if (w0_en && w0_idx == RFIDX_W'(r))  mem[r] <= w0_dat;
      end
    end
  end

  always_comb begin
    rf = '0;
    for (int r = 1; r < NREG; r++) rf[r] = mem[r];
  end
endmodule

module e203_exu_mt_regfile #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5,
  parameter int THREADS = 2,
  parameter int TID_W   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [TID_W-1:0]          read_src1_tid,
  input  logic [RFIDX_W-1:0]        read_src1_idx,
  output logic [XLEN-1:0]           read_src1_dat,
  input  logic [TID_W-1:0]          read_src2_tid,
  input  logic [RFIDX_W-1:0]        read_src2_idx,
  output logic [XLEN-1:0]           read_src2_dat,
  input  logic                      wbck0_wen,
  input  logic [TID_W-1:0]          wbck0_tid,
  input  logic [RFIDX_W-1:0]        wbck0_idx,
  input  logic [XLEN-1:0]           wbck0_dat,
  input  logic                      wbck1_wen,
  input  logic [TID_W-1:0]          wbck1_tid,
  input  logic [RFIDX_W-1:0]        wbck1_idx,
  input  logic [XLEN-1:0]           wbck1_dat,
  input  logic                      clr_req,
  input  logic [TID_W-1:0]          clr_tid,
  output logic                      clr_busy,
  output logic                      clr_done,
  output logic [THREADS*XLEN-1:0]   x1_r
);
  localparam int NREG = 1 << RFIDX_W;

  typedef struct packed {
    logic               en;
    logic [TID_W-1:0]   tid;
    logic [RFIDX_W-1:0] idx;
    logic [XLEN-1:0]    dat;
  } wreq_t;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                              state, state_d;
  logic [RFIDX_W-1:0]                  cnt, cnt_d;
  logic [TID_W-1:0]                    ctid, ctid_d;
  logic                                done_q, done_d;
  wreq_t [1:0]                         wr_raw, wr;
  logic [THREADS-1:0][NREG-1:0][XLEN-1:0] rf;
  logic [1:0][TID_W-1:0]               rd_tid;
  logic [1:0][RFIDX_W-1:0]             rd_idx;

  function automatic logic tid_ok(input logic [TID_W-1:0] t);
    return 32'(t) < THREADS;
  endfunction

  assign wr_raw[0] = {wbck0_wen, wbck0_tid, wbck0_idx, wbck0_dat};
  assign wr_raw[1] = {wbck1_wen, wbck1_tid, wbck1_idx, wbck1_dat};
  assign rd_tid    = {read_src2_tid, read_src1_tid};
  assign rd_idx    = {read_src2_idx, read_src1_idx};

  // Writes into the context being cleared are dropped entirely (no store, no bypass).
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wr[p]    = wr_raw[p];
      wr[p].en = wr_raw[p].en && (wr_raw[p].idx != '0) && tid_ok(wr_raw[p].tid) &&
                 !(clr_busy && wr_raw[p].tid == ctid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ctid   <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      ctid   <= ctid_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ctid_d  = ctid;
    done_d  = 1'b0;
    case (state)
      IDLE: if (clr_req && tid_ok(clr_tid)) begin
        state_d = CLEAR;
        cnt_d   = RFIDX_W'(1);
        ctid_d  = clr_tid;
      end
      CLEAR: begin
        cnt_d = cnt + 1'b1;
        if (cnt == RFIDX_W'(NREG-1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state == CLEAR);
    clr_done = done_q;
  end

  for (genvar t = 0; t < THREADS; t++) begin : g_ctx
    logic hit0, hit1, clr_hit;
    assign hit0    = wr[0].en && wr[0].tid == TID_W'(t);
    assign hit1    = wr[1].en && wr[1].tid == TID_W'(t);
    assign clr_hit = clr_busy && ctid == TID_W'(t);

    e203_exu_mt_regfile_ctx #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .NREG(NREG)) u_ctx (
      .clk     (clk),
      .rst     (rst),
      .w0_en   (hit0),
      .w0_idx  (wr[0].idx),
      .w0_dat  (wr[0].dat),
      .w1_en   (hit1),
      .w1_idx  (wr[1].idx),
      .w1_dat  (wr[1].dat),
      .clr_en  (clr_hit),
      .clr_idx (cnt),
      .rf      (rf[t])
    );

    assign x1_r[t*XLEN +: XLEN] = rf[t][1];
  end

  // Read mux with write-through bypass; port 1 is applied last so it wins.
  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic [XLEN-1:0] dat;
    always_comb begin
      dat = '0;
      if (rd_idx[p] != '0 && tid_ok(rd_tid[p])) begin
        for (int t = 0; t < THREADS; t++)
          if (rd_tid[p] == TID_W'(t)) dat = rf[t][rd_idx[p]];
        for (int w = 0; w < 2; w++)
          if (wr[w].en && wr[w].tid == rd_tid[p] && wr[w].idx == rd_idx[p]) dat = wr[w].dat;
      end
    end
  end

  assign read_src1_dat = g_rd[0].dat;
  assign read_src2_dat = g_rd[1].dat;
endmodule

// File: tb/tb_e203_exu_mt_regfile.sv
// Scoreboard bench: the driver queues expected values per cycle, a negedge monitor compares.
module tb_e203_exu_mt_regfile;
  localparam int XLEN = 32, RFIDX_W = 5, THREADS = 2, TID_W = 1, NREG = 32;

  logic clk = 1'b0, rst = 1'b1;
  logic [TID_W-1:0] read_src1_tid, read_src2_tid, wbck0_tid, wbck1_tid, clr_tid;
  logic [RFIDX_W-1:0] read_src1_idx, read_src2_idx, wbck0_idx, wbck1_idx;
  logic [XLEN-1:0] read_src1_dat, read_src2_dat, wbck0_dat, wbck1_dat;
  logic wbck0_wen, wbck1_wen, clr_req, clr_busy, clr_done;
  logic [THREADS*XLEN-1:0] x1_r;

  e203_exu_mt_regfile #(.XLEN(XLEN), .RFIDX_W(RFIDX_W), .THREADS(THREADS), .TID_W(TID_W)) dut (
    .clk(clk), .rst(rst),
    .read_src1_tid(read_src1_tid), .read_src1_idx(read_src1_idx), .read_src1_dat(read_src1_dat),
    .read_src2_tid(read_src2_tid), .read_src2_idx(read_src2_idx), .read_src2_dat(read_src2_dat),
    .wbck0_wen(wbck0_wen), .wbck0_tid(wbck0_tid), .wbck0_idx(wbck0_idx), .wbck0_dat(wbck0_dat),
    .wbck1_wen(wbck1_wen), .wbck1_tid(wbck1_tid), .wbck1_idx(wbck1_idx), .wbck1_dat(wbck1_dat),
    .clr_req(clr_req), .clr_tid(clr_tid), .clr_busy(clr_busy), .clr_done(clr_done), .x1_r(x1_r)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  localparam int K_RD1 = 0, K_RD2 = 1, K_BUSY = 2, K_DONE = 3, K_X1T0 = 4, K_X1T1 = 5;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0, errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int kind);
    case (kind)
      K_RD1:   return read_src1_dat;
      K_RD2:   return read_src2_dat;
      K_BUSY:  return {31'b0, clr_busy};
      K_DONE:  return {31'b0, clr_done};
      K_X1T0:  return x1_r[31:0];
      default: return x1_r[63:32];
    endcase
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        logic [31:0] got;
        e   = q.pop_front();
        got = sample(e.kind);
        checks++;
        if (e.cyc != cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)", e.name, e.cyc, cyc);
        end else if (got !== e.exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", e.name, got, e.exp, cyc);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input int kind, input logic [31:0] v, input string n);
    q.push_back('{cyc, kind, v, n});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wbck0_wen = 0; wbck0_tid = 0; wbck0_idx = 0; wbck0_dat = 0;
    wbck1_wen = 0; wbck1_tid = 0; wbck1_idx = 0; wbck1_dat = 0;
    clr_req = 0; clr_tid = 0;
    read_src1_tid = 0; read_src1_idx = 0; read_src2_tid = 0; read_src2_idx = 0;
  endtask

  task automatic w0(input logic t, input int i, input logic [31:0] d);
    wbck0_wen = 1; wbck0_tid = t; wbck0_idx = RFIDX_W'(i); wbck0_dat = d;
  endtask

  task automatic w1(input logic t, input int i, input logic [31:0] d);
    wbck1_wen = 1; wbck1_tid = t; wbck1_idx = RFIDX_W'(i); wbck1_dat = d;
  endtask

  task automatic rd(input logic t1, input int i1, input logic t2, input int i2);
    read_src1_tid = t1; read_src1_idx = RFIDX_W'(i1);
    read_src2_tid = t2; read_src2_idx = RFIDX_W'(i2);
  endtask

  // t0 gets b0+i, t1 gets b1+i for x1..x31
  task automatic fill(input logic [31:0] b0, input logic [31:0] b1);
    for (int i = 1; i < NREG; i++) begin
      w0(0, i, b0 + i); w1(1, i, b1 + i); step();
    end
    wbck0_wen = 0; wbck1_wen = 0;
  endtask

  initial begin
    idle_in();
    step(); step();
    chk(K_BUSY, 0, "rst_busy"); chk(K_DONE, 0, "rst_done");
    chk(K_X1T0, 0, "rst_x1t0"); chk(K_X1T1, 0, "rst_x1t1");
    step();
    rst = 0;

    // write then read, with same-cycle bypass
    w0(0, 5, 32'hDEADBEEF); rd(0, 5, 1, 5);
    chk(K_RD1, 32'hDEADBEEF, "byp_t0x5"); chk(K_RD2, 0, "byp_t1x5");
    step();
    wbck0_wen = 0;
    chk(K_RD1, 32'hDEADBEEF, "rd_t0x5"); chk(K_RD2, 0, "rd_t1x5");
    step();

    // both ports hit t1 x7: port 1 wins for bypass and storage
    w0(1, 7, 32'h11); w1(1, 7, 32'h22); rd(1, 7, 0, 7);
    chk(K_RD1, 32'h22, "coll_byp"); chk(K_RD2, 0, "coll_t0x7");
    step();
    wbck0_wen = 0; wbck1_wen = 0;
    chk(K_RD1, 32'h22, "coll_store");
    step();

    // x0 is hardwired zero
    w1(0, 0, 32'hFFFFFFFF); rd(0, 0, 0, 0);
    chk(K_RD1, 0, "x0_byp1"); chk(K_RD2, 0, "x0_byp2");
    step();
    wbck1_wen = 0;
    chk(K_RD1, 0, "x0_rd1"); chk(K_RD2, 0, "x0_rd2");
    step();

    fill(32'h200, 32'h100);
    rd(1, 31, 0, 5);
    chk(K_RD1, 32'h11F, "fill_t1x31"); chk(K_RD2, 32'h205, "fill_t0x5");
    chk(K_X1T0, 32'h201, "fill_x1t0"); chk(K_X1T1, 32'h101, "fill_x1t1");
    step();

    // clear t1; a request held during CLEAR must be ignored
    clr_req = 1; clr_tid = 1;
    chk(K_BUSY, 0, "clr1_req_busy");
    step();
    clr_tid = 0;
    for (int i = 1; i < NREG; i++) begin
      if (i == 4) clr_req = 0;
      if (i == 1) begin
        rd(1, 31, 1, 1);
        chk(K_RD1, 32'h11F, "clr1_rd_x31");
        chk(K_RD2, 32'h101, "clr1_nobyp_x1");
      end
      chk(K_BUSY, 1, $sformatf("clr1_busy_%0d", i));
      chk(K_DONE, 0, $sformatf("clr1_done_%0d", i));
      step();
    end
    chk(K_BUSY, 0, "clr1_end_busy"); chk(K_DONE, 1, "clr1_done_pulse");
    chk(K_X1T1, 0, "clr1_x1t1"); chk(K_X1T0, 32'h201, "clr1_x1t0");

    // request in the clr_done cycle starts a t0 clear
    clr_req = 1; clr_tid = 0;
    step();
    clr_req = 0;
    w0(0, 3, 32'h5); w1(1, 3, 32'h9); rd(0, 3, 1, 3);
    chk(K_RD1, 32'h203, "clr0_nobyp_t0x3"); chk(K_RD2, 32'h9, "clr0_byp_t1x3");
    chk(K_BUSY, 1, "clr0_busy_1"); chk(K_DONE, 0, "clr0_done_1");
    step();
    wbck0_wen = 0; wbck1_wen = 0;
    for (int i = 2; i < NREG; i++) begin
      chk(K_BUSY, 1, $sformatf("clr0_busy_%0d", i));
      step();
    end
    chk(K_BUSY, 0, "clr0_end_busy"); chk(K_DONE, 1, "clr0_done_pulse");
    chk(K_X1T0, 0, "clr0_x1t0");
    step();
    chk(K_DONE, 0, "clr0_done_once");
    for (int i = 0; i < NREG; i++) begin
      rd(0, i, 1, i);
      chk(K_RD1, 0, $sformatf("clr0_t0x%0d", i));
      chk(K_RD2, (i == 3) ? 32'h9 : 32'h0, $sformatf("clr0_t1x%0d", i));
      step();
    end

    // reset while clearing t0 at counter 10
    fill(32'h300, 32'h400);
    clr_req = 1; clr_tid = 0;
    step();
    clr_req = 0;
    for (int i = 1; i <= 10; i++) begin
      chk(K_BUSY, 1, $sformatf("rstclr_busy_%0d", i));
      if (i == 10) rst = 1;
      step();
    end
    chk(K_BUSY, 0, "rstclr_busy"); chk(K_DONE, 0, "rstclr_done");
    chk(K_X1T0, 0, "rstclr_x1t0"); chk(K_X1T1, 0, "rstclr_x1t1");
    rst = 0;
    step();
    chk(K_DONE, 0, "rstclr_nodone"); chk(K_BUSY, 0, "rstclr_idle");
    step();
    for (int i = 0; i < NREG; i++) begin
      rd(0, i, 1, i);
      chk(K_RD1, 0, $sformatf("rstclr_t0x%0d", i));
      chk(K_RD2, 0, $sformatf("rstclr_t1x%0d", i));
      step();
    end

    step(); step();
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d expectations unchecked, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
